// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// funct decode helpers, and the sign-correction policy used at the end of an operation.
package mdu_iterative_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CALC   = 2'b01,
        S_FINISH = 2'b10
    } mdu_state_e;

    typedef struct packed {
        logic neg_prod;
        logic neg_quot;
        logic neg_rem;
    } sign_ctl_t;

    // R-type funct 0110xx selects the multiply/divide group; the low two bits pick the op.
    localparam logic [3:0] FUNCT_MDU_GRP = 4'b0110;

    function automatic logic is_mdu_funct(input logic [5:0] funct);
        return funct[5:2] == FUNCT_MDU_GRP;
    endfunction

    function automatic mdu_op_e funct_to_op(input logic [5:0] funct);
        return mdu_op_e'(funct[1:0]);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Which result fields need negating, given the latched operand signs.
    function automatic sign_ctl_t sign_ctl(input mdu_op_e op, input logic sa, input logic sb);
        sign_ctl_t s;
        s = '0;
        case (op)
            OP_MULT: s.neg_prod = sa ^ sb;
            OP_DIV: begin
                s.neg_quot = sa ^ sb;
                s.neg_rem  = sa;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative MDU: shift-add multiply and restoring divide on unsigned magnitudes,
// one bit per cycle, with sign correction applied in a single FINISH cycle.
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mdu_op_e            op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               zdiv_q, zdiv_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               in_signed;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     sh_rem;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod_fix;
    sign_ctl_t          sc;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        raw_a_d   = raw_a_q;
        zdiv_d    = zdiv_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        in_signed = op_is_signed(mdu_op_e'(op));
        // Multiply: multiplier LSB gates a WIDTH+1-bit add into the upper half.
        msum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
        // Divide: next dividend bit comes from the MSB of the left-shifting dividend.
        sh_rem    = {acc_q[2*WIDTH-1:WIDTH], mag_a_q[WIDTH-1]};
        diff      = sh_rem - {1'b0, mag_b_q};
        ge        = (sh_rem >= {1'b0, mag_b_q});
        sc        = sign_ctl(op_q, sa_q, sb_q);
        prod_fix  = sc.neg_prod ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = mdu_op_e'(op);
                    sa_d    = in_signed && operand_a[WIDTH-1];
                    sb_d    = in_signed && operand_b[WIDTH-1];
                    mag_a_d = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
                    mag_b_d = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
                    raw_a_d = operand_a;
                    zdiv_d  = op[1] && (operand_b == '0);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (op_is_div(op_q)) begin
                    acc_d   = {(ge ? diff[WIDTH-1:0] : sh_rem[WIDTH-1:0]),
                               acc_q[WIDTH-2:0], ge};
                    mag_a_d = mag_a_q << 1;
                end else begin
                    acc_d   = {msum, acc_q[WIDTH-1:1]};
                    mag_b_d = mag_b_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (!op_is_div(op_q)) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (zdiv_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = sc.neg_rem  ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = sc.neg_quot ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                dbz_d   = zdiv_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            raw_a_q <= '0;
            zdiv_q  <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            raw_a_q <= raw_a_d;
            zdiv_q  <= zdiv_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: expected results queued at issue, checked on done.
module tb_mdu_iterative;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi_out, lo_out;

    mdu_iterative #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int ndone = 0;
    int done_edge = 0;
    int e0 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) ecnt++;

    // Monitor: every done pulse pops one scoreboard entry.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            ndone++;
            done_edge = ecnt;
            if (sb.size() == 0) begin
                check("unexpected_done", {63'b0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi_out", {32'b0, hi_out}, {32'b0, e.hi});
                check("lo_out", {32'b0, lo_out}, {32'b0, e.lo});
                check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
            end
        end
    end

    // Called at a negedge; start is sampled on the following rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz);
        exp_t e;
        start = 1'b1;
        op = o;
        operand_a = x;
        operand_b = y;
        if (push) begin
            e.hi = ehi;
            e.lo = elo;
            e.dbz = edbz;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        e0 = ecnt;
        start = 1'b0;
    endtask

    // Returns at the negedge inside the done-high cycle.
    task automatic wait_done(input string tag);
        int n = ndone;
        int t = 0;
        while (ndone == n && t < 100) begin
            @(negedge clock);
            t++;
        end
        check({tag, "_seen"}, 64'(ndone - n), 64'd1);
        check({tag, "_latency"}, 64'(done_edge - e0), 64'd33);
        check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        check("rst_hi", {32'b0, hi_out}, 64'd0);
        check("rst_lo", {32'b0, lo_out}, 64'd0);
        reset = 1'b1;

        // multu max * max
        @(negedge clock);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("multu_busy", {63'b0, busy}, 64'd1);
        wait_done("multu");
        @(negedge clock);
        check("done_pulse_width", {63'b0, done}, 64'd0);

        // mult -3*7, with a start while busy that must be ignored
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        repeat (5) @(negedge clock);
        start = 1'b1;
        op = 2'b01;
        operand_a = 32'd2;
        operand_b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        check("mult_busy_after_ignored", {63'b0, busy}, 64'd1);
        wait_done("mult");
        n = ndone;
        repeat (40) @(negedge clock);
        check("ignored_start_no_done", 64'(ndone - n), 64'd0);
        check("mult_hi_held", {32'b0, hi_out}, 64'h0000_0000_FFFF_FFFF);

        // div -7/2 and the signed overflow case
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_neg");
        @(negedge clock);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done("div_ovf");

        // divu by zero
        @(negedge clock);
        issue(2'b11, 32'd100, 32'd0, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        wait_done("divu_zero");
        check("dbz_high_with_done", {63'b0, div_by_zero}, 64'd1);
        @(negedge clock);
        check("dbz_pulse_width", {63'b0, div_by_zero}, 64'd0);

        // reset mid-operation discards the result
        issue(2'b01, 32'd6, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        n = ndone;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_hi", {32'b0, hi_out}, 64'd0);
        check("midrst_lo", {32'b0, lo_out}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("midrst_no_done", 64'(ndone - n), 64'd0);

        issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_done("divu_after_rst");

        // back-to-back: second start in the done-high cycle
        @(negedge clock);
        issue(2'b11, 32'd1000, 32'd33, 1'b1, 32'd10, 32'd30, 1'b0);
        wait_done("b2b_first");
        issue(2'b00, 32'd5, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);
        check("b2b_busy", {63'b0, busy}, 64'd1);
        wait_done("b2b_second");

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
